// File: rtl/ghr_spec_queue.sv
`default_nettype none
// ============================================================================
// Module   : ghr_spec_queue
// Purpose  : Speculative global-history register with an in-order checkpoint
//            queue and a committed (architectural) history. Predictions push
//            a checkpoint and shift the speculative GHR. Resolutions retire
//            the oldest checkpoint. A misprediction rebuilds both histories
//            from the checkpoint and flushes every younger entry.
// Revision : 1.0 - initial release
// ============================================================================
module ghr_spec_queue #(
    parameter int GHR_W = 20,
    parameter int MAX_B = 8,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(MAX_B + 1),
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,            // asynchronous, active-low
    input  logic               i_predValid,
    output logic               o_predReady,
    input  logic [CNT_W-1:0]   i_passBNum,
    input  logic               i_predictGotJ,
    output logic [GHR_W-1:0]   o_ghr,
    output logic [PTR_W-1:0]   o_tag,
    input  logic               i_resValid,
    input  logic               i_resErr,
    input  logic               i_resTaken,
    input  logic [CNT_W-1:0]   i_resBPos,
    output logic               o_resReady,
    output logic [GHR_W-1:0]   o_commitGhr,
    output logic [PTR_W:0]     o_count,
    output logic               o_empty,
    output logic               o_full
);

    localparam logic [CNT_W-1:0] c_max_b = CNT_W'(MAX_B);
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);
    localparam logic [PTR_W:0]   c_depth = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] c_ptr_1 = PTR_W'(1);
    localparam logic [PTR_W:0]   c_cnt_1 = (PTR_W + 1)'(1);

    // Branch counts above MAX_B are saturated before use
    function automatic logic [CNT_W-1:0] f_clamp(input logic [CNT_W-1:0] n);
        return (n > c_max_b) ? c_max_b : n;
    endfunction

    // History shift: n-1 not-taken bits followed by the block outcome bit
    function automatic logic [GHR_W-1:0] f_shift(input logic [GHR_W-1:0] g,
                                                 input logic [CNT_W-1:0] n,
                                                 input logic             b);
        logic [CNT_W-1:0] n_c;
        n_c = f_clamp(n);
        if (n_c == '0)
            return g;
        return (g << n_c) | {{(GHR_W-1){1'b0}}, b};
    endfunction

    // Checkpoint storage (data only, no reset needed)
    logic [GHR_W-1:0] r_pre_ghr [DEPTH];
    logic [CNT_W-1:0] r_n       [DEPTH];
    logic             r_gotj    [DEPTH];

    logic [GHR_W-1:0] r_ghr;
    logic [GHR_W-1:0] r_commit;
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W:0]   r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_err;
    logic             w_push_eff;
    logic [CNT_W-1:0] w_bpos;
    logic [GHR_W-1:0] w_ok_ghr;
    logic [GHR_W-1:0] w_err_ghr;

    assign w_full     = (r_count == c_depth);
    assign w_empty    = (r_count == '0);
    assign w_push     = i_predValid & ~w_full;
    assign w_pop      = i_resValid & ~w_empty;
    assign w_err      = w_pop & i_resErr;
    // A flush in the same cycle discards the incoming prediction
    assign w_push_eff = w_push & ~w_err;

    assign w_bpos     = (i_resBPos == '0) ? c_one : f_clamp(i_resBPos);
    assign w_ok_ghr   = f_shift(r_pre_ghr[r_rd], r_n[r_rd], r_gotj[r_rd]);
    assign w_err_ghr  = f_shift(r_pre_ghr[r_rd], w_bpos, i_resTaken);

    // Capture a checkpoint for every accepted prediction
    always_ff @(posedge clk) begin
        if (w_push_eff) begin
            r_pre_ghr[r_wr] <= r_ghr;
            r_n[r_wr]       <= f_clamp(i_passBNum);
            r_gotj[r_wr]    <= i_predictGotJ;
        end
    end

    // Histories, pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ghr    <= '0;
            r_commit <= '0;
            r_wr     <= '0;
            r_rd     <= '0;
            r_count  <= '0;
        end else if (w_err) begin
            r_ghr    <= w_err_ghr;
            r_commit <= w_err_ghr;
            r_rd     <= r_wr;
            r_count  <= '0;
        end else begin
            if (w_push_eff) begin
                r_ghr <= f_shift(r_ghr, i_passBNum, i_predictGotJ);
                r_wr  <= r_wr + c_ptr_1;
            end
            if (w_pop) begin
                r_commit <= w_ok_ghr;
                r_rd     <= r_rd + c_ptr_1;
            end
            if (w_push_eff && !w_pop)
                r_count <= r_count + c_cnt_1;
            else if (!w_push_eff && w_pop)
                r_count <= r_count - c_cnt_1;
        end
    end

    assign o_ghr       = r_ghr;
    assign o_commitGhr = r_commit;
    assign o_tag       = r_wr;
    assign o_count     = r_count;
    assign o_empty     = w_empty;
    assign o_full      = w_full;
    assign o_predReady = ~w_full;
    assign o_resReady  = ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_ghr_spec_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ghr_spec_queue
// Purpose  : Self-checking bench for ghr_spec_queue: directed vector table,
//            hand-written corner sequences and a randomized run against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ghr_spec_queue;

    localparam int GHR_W = 20;
    localparam int CNT_W = 4;
    localparam int PTR_W = 3;

    logic               clk;
    logic               rst;
    logic               pred_valid;
    logic               pred_ready;
    logic [CNT_W-1:0]   pass_bnum;
    logic               pred_gotj;
    logic [GHR_W-1:0]   ghr;
    logic [PTR_W-1:0]   tag;
    logic               res_valid;
    logic               res_err;
    logic               res_taken;
    logic [CNT_W-1:0]   res_bpos;
    logic               res_ready;
    logic [GHR_W-1:0]   commit_ghr;
    logic [PTR_W:0]     count;
    logic               empty;
    logic               full;

    int n_cmp;
    int n_bad;

    ghr_spec_queue dut (
        .clk          (clk),
        .rst          (rst),
        .i_predValid  (pred_valid),
        .o_predReady  (pred_ready),
        .i_passBNum   (pass_bnum),
        .i_predictGotJ(pred_gotj),
        .o_ghr        (ghr),
        .o_tag        (tag),
        .i_resValid   (res_valid),
        .i_resErr     (res_err),
        .i_resTaken   (res_taken),
        .i_resBPos    (res_bpos),
        .o_resReady   (res_ready),
        .o_commitGhr  (commit_ghr),
        .o_count      (count),
        .o_empty      (empty),
        .o_full       (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       pv;
        int       n;
        bit       j;
        bit       rv;
        bit       err;
        bit       tk;
        int       bpos;
        int       e_ghr;
        int       e_commit;
        int       e_count;
        int       e_tag;
    } vec_t;

    typedef struct {
        logic [GHR_W-1:0] pre;
        int               n;
        bit               j;
    } ent_t;

    // Reference history update: insert one bit at a time
    function automatic logic [GHR_W-1:0] m_sh(logic [GHR_W-1:0] g, int n, bit b);
        int k;
        k = (n > 8) ? 8 : n;
        for (int i = 0; i < k; i++)
            g = {g[GHR_W-2:0], (i == k - 1) ? b : 1'b0};
        return g;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit pv, input int n, input bit j,
                         input bit rv, input bit err, input bit tk, input int bp);
        pred_valid = pv;
        pass_bnum  = CNT_W'(n);
        pred_gotj  = j;
        res_valid  = rv;
        res_err    = err;
        res_taken  = tk;
        res_bpos   = CNT_W'(bp);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
    endtask

    vec_t vecs[11];

    // Reference model state
    ent_t             mq[$];
    logic [GHR_W-1:0] m_ghr;
    logic [GHR_W-1:0] m_commit;
    int               m_tag;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b0;
        idle();

        vecs[0]  = '{1, 3, 1, 0, 0, 0, 0, 'h00001, 'h0,    1, 1};
        vecs[1]  = '{1, 2, 0, 0, 0, 0, 0, 'h00004, 'h0,    2, 2};
        vecs[2]  = '{0, 0, 0, 1, 0, 0, 0, 'h00004, 'h1,    1, 2};
        vecs[3]  = '{0, 0, 0, 1, 0, 0, 0, 'h00004, 'h4,    0, 2};
        vecs[4]  = '{1, 1, 1, 0, 0, 0, 0, 'h00009, 'h4,    1, 3};
        vecs[5]  = '{1, 12, 0, 0, 0, 0, 0, 'h00900, 'h4,   2, 4};
        vecs[6]  = '{1, 1, 1, 1, 1, 1, 2, 'h00011, 'h11,   0, 4};
        vecs[7]  = '{1, 0, 1, 1, 1, 1, 3, 'h00011, 'h11,   1, 5};
        vecs[8]  = '{0, 0, 0, 1, 1, 0, 0, 'h00022, 'h22,   0, 5};
        vecs[9]  = '{1, 3, 1, 1, 0, 0, 0, 'h00111, 'h22,   1, 6};
        vecs[10] = '{0, 0, 0, 1, 1, 1, 15, 'h02201, 'h2201, 0, 6};

        // Reset state
        do_reset();
        chk("rst_ghr", int'(ghr), 0);
        chk("rst_commit", int'(commit_ghr), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_predReady", int'(pred_ready), 1);
        chk("rst_resReady", int'(res_ready), 0);
        chk("rst_tag", int'(tag), 0);
        chk("rst_count", int'(count), 0);

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].pv, vecs[i].n, vecs[i].j, vecs[i].rv,
                  vecs[i].err, vecs[i].tk, vecs[i].bpos);
            tick();
            chk($sformatf("vec%0d_ghr", i), int'(ghr), vecs[i].e_ghr);
            chk($sformatf("vec%0d_commit", i), int'(commit_ghr), vecs[i].e_commit);
            chk($sformatf("vec%0d_count", i), int'(count), vecs[i].e_count);
            chk($sformatf("vec%0d_tag", i), int'(tag), vecs[i].e_tag);
        end
        idle();

        // Flush with a simultaneous push: push is dropped
        do_reset();
        drive(1, 3, 1, 0, 0, 0, 0); tick();
        drive(1, 2, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 1, 1, 1, 1, 2); tick();
        idle();
        chk("flush_ghr", int'(ghr), 'h1);
        chk("flush_commit", int'(commit_ghr), 'h1);
        chk("flush_count", int'(count), 0);
        chk("flush_tag", int'(tag), 2);
        tick();
        chk("flush_ghr_hold", int'(ghr), 'h1);

        // Fill to full, then an extra push is refused
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 1, 0, 0, 0, 0);
            tick();
        end
        chk("full_flag", int'(full), 1);
        chk("full_predReady", int'(pred_ready), 0);
        chk("full_ghr", int'(ghr), 'hFF);
        // Full with a pop offered: ready must still be low
        drive(1, 1, 1, 1, 0, 0, 0);
        #1;
        chk("full_ready_pop", int'(pred_ready), 0);
        drive(1, 1, 1, 0, 0, 0, 0);
        tick();
        chk("full_ghr_hold", int'(ghr), 'hFF);
        chk("full_count_hold", int'(count), 8);
        chk("full_tag_wrap", int'(tag), 0);
        idle();

        // Saturated history, clamped and zero-length shifts, async reset
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 1, (i > 0), 0, 0, 0);
            tick();
        end
        chk("sat_ghr", int'(ghr), 'hFFFFF);
        drive(1, 8, 1, 0, 0, 0, 0); tick();
        chk("sh8_ghr", int'(ghr), 'hFFF01);
        drive(1, 0, 1, 0, 0, 0, 0); tick();
        chk("sh0_ghr", int'(ghr), 'hFFF01);
        idle();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_ghr", int'(ghr), 0);
        chk("arst_commit", int'(commit_ghr), 0);
        chk("arst_count", int'(count), 0);
        chk("arst_tag", int'(tag), 0);
        chk("arst_resReady", int'(res_ready), 0);
        repeat (2) tick();
        rst = 1'b1;

        // Randomized run against the reference model
        do_reset();
        mq.delete();
        m_ghr    = '0;
        m_commit = '0;
        m_tag    = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            bit pv, rv, er, tk, jj;
            int nn, bp;
            bit m_push, m_pop;
            ent_t e;
            pv = ($urandom_range(0, 99) < 60);
            rv = ($urandom_range(0, 99) < 50);
            er = ($urandom_range(0, 99) < 15);
            tk = 1'($urandom_range(0, 1));
            jj = 1'($urandom_range(0, 1));
            nn = $urandom_range(0, 15);
            bp = $urandom_range(0, 15);
            drive(pv, nn, jj, rv, er, tk, bp);
            #1;
            chk("rnd_predReady", int'(pred_ready), int'(mq.size() < 8));
            chk("rnd_resReady", int'(res_ready), int'(mq.size() > 0));
            m_push = pv && (mq.size() < 8);
            m_pop  = rv && (mq.size() > 0);
            if (m_pop && er) begin
                int b;
                b = (bp == 0) ? 1 : ((bp > 8) ? 8 : bp);
                m_ghr    = m_sh(mq[0].pre, b, tk);
                m_commit = m_ghr;
                mq.delete();
            end else begin
                if (m_pop) begin
                    e = mq.pop_front();
                    m_commit = m_sh(e.pre, e.n, e.j);
                end
                if (m_push) begin
                    e.pre = m_ghr;
                    e.n   = (nn > 8) ? 8 : nn;
                    e.j   = jj;
                    mq.push_back(e);
                    m_ghr = m_sh(m_ghr, nn, jj);
                    m_tag = (m_tag + 1) % 8;
                end
            end
            tick();
            chk("rnd_ghr", int'(ghr), int'(m_ghr));
            chk("rnd_commit", int'(commit_ghr), int'(m_commit));
            chk("rnd_count", int'(count), mq.size());
            chk("rnd_tag", int'(tag), m_tag);
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
